// File: rtl/reset_sequencer.sv
// reset_sequencer: qualifies PLL lock, then releases staged resets in ascending order
module reset_sequencer #(
   parameter int STAGES      = 4,
   parameter int HOLD        = 16,
   parameter int LOCK_FILTER = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_locked,
   input  logic              i_sw_rst,
   output logic [STAGES-1:0] o_rst,
   output logic              o_ready
);
   localparam int LW = $clog2(LOCK_FILTER + 1);
   localparam int TW = $clog2(HOLD + 1);
   localparam int IW = $clog2(STAGES + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(STAGES - 1);
   typedef enum logic [1:0] {LOCK, STAGE, RUN} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] rst_sync;
   logic [SYNC_STAGES-1:0] lock_sync;
   logic rst_int;
   logic locked_s;
   logic fault;
   logic [LW-1:0] lock_cnt;
   logic [TW-1:0] timer;
   logic [IW-1:0] idx;
   assign rst_int  = rst_sync[SYNC_STAGES-1];
   assign locked_s = lock_sync[SYNC_STAGES-1];
   assign fault    = !locked_s || i_sw_rst;
   // internal reset: asserts with i_rst, deasserts after SYNC_STAGES clean edges
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst)
         rst_sync <= '1;
      else
         rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b0};
   // lock synchronizer, left unreset so lock status is already valid when reset lifts
   always_ff @(posedge i_clk)
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], i_locked};
   // lock qualification, staged release and fault recovery; o_rst stays a thermometer code
   always_ff @(posedge i_clk or posedge rst_int)
      if (rst_int) begin
         state    <= LOCK;
         lock_cnt <= '0;
         timer    <= '0;
         idx      <= '0;
         o_rst    <= '1;
         o_ready  <= 1'b0;
      end else if (state == LOCK) begin
         if (fault)
            lock_cnt <= '0;
         else if (lock_cnt == LOCK_LAST) begin
            lock_cnt <= '0;
            timer    <= '0;
            idx      <= '0;
            state    <= STAGE;
         end else
            lock_cnt <= lock_cnt + 1'b1;
      end else if (fault) begin
         state    <= LOCK;
         lock_cnt <= '0;
         timer    <= '0;
         idx      <= '0;
         o_rst    <= '1;
         o_ready  <= 1'b0;
      end else if (state == STAGE) begin
         if (timer == HOLD_LAST) begin
            timer <= '0;
            idx   <= idx + 1'b1;
            o_rst <= {STAGES{1'b1}} << (idx + 1'b1);
            if (idx == IDX_LAST) begin
               state   <= RUN;
               o_ready <= 1'b1;
            end
         end else
            timer <= timer + 1'b1;
      end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized checks against an elapsed-time reference model
module tb_reset_sequencer;
   localparam int S = 4;
   localparam int H = 16;
   localparam int LF = 8;
   localparam int SY = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic locked = 1'b1;
   logic sw_rst = 1'b0;
   logic [S-1:0] o_rst;
   logic o_ready;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int base = 0;
   bit mon = 1'b0;
   // reference model: internal-reset edge count, qualifying-lock run length, time since lock
   int rcnt = 0;
   int n = 0;
   int e = 0;
   bit rint = 1'b1;
   bit run = 1'b0;
   bit q[$];
   bit pre;
   bit ls;
   int r_exp;
   logic [S-1:0] eo;
   logic [S-1:0] rel;

   reset_sequencer #(.STAGES(S), .HOLD(H), .LOCK_FILTER(LF), .SYNC_STAGES(SY)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_locked(locked),
      .i_sw_rst(sw_rst),
      .o_rst(o_rst),
      .o_ready(o_ready)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // model step on every rising edge using the inputs that were stable before it
   initial begin
      repeat (SY) q.push_back(1'b0);
      forever begin
         @(posedge clk);
         pre = rint || rst;
         ls = q[q.size() - SY];
         q.push_back(locked);
         if (q.size() > 8) void'(q.pop_front());
         rcnt = rst ? 0 : (rcnt < SY ? rcnt + 1 : rcnt);
         rint = rst || rcnt < SY;
         if (pre) begin
            run = 0;
            n = 0;
            e = 0;
         end else if (!run) begin
            if (!ls || sw_rst) n = 0;
            else begin
               n++;
               if (n == LF) begin
                  run = 1;
                  n = 0;
                  e = 0;
               end
            end
         end else if (!ls || sw_rst) begin
            run = 0;
            n = 0;
            e = 0;
         end else if (e < H * S) e++;
      end
   end

   // continuous comparison on the falling edge: model outputs and structural invariants
   initial forever begin
      @(negedge clk);
      if (mon) begin
         r_exp = (rst || !run) ? 0 : (e / H > S ? S : e / H);
         eo = {S{1'b1}} << r_exp;
         checks++;
         if (o_rst !== eo) begin
            errors++;
            $display("FAIL model_o_rst cyc=%0d got=%b exp=%b", cyc, o_rst, eo);
         end
         checks++;
         if (o_ready !== (r_exp == S)) begin
            errors++;
            $display("FAIL model_o_ready cyc=%0d got=%b exp=%b", cyc, o_ready, r_exp == S);
         end
         rel = ~o_rst;
         checks++;
         if ((rel & (rel + 1'b1)) != '0) begin
            errors++;
            $display("FAIL thermometer cyc=%0d got=%b", cyc, o_rst);
         end
         checks++;
         if (o_ready !== (o_rst == '0)) begin
            errors++;
            $display("FAIL ready_invariant cyc=%0d o_ready=%b o_rst=%b", cyc, o_ready, o_rst);
         end
      end
   end

   task automatic wait_to(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold_rst();
      @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic release_rst();
      @(posedge clk);
      #2;
      rst = 1'b0;
      base = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      locked = 1'b1;
      sw_rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (o_rst !== {S{1'b1}}) begin
         errors++;
         $display("FAIL reset_o_rst got=%b exp=%b", o_rst, {S{1'b1}});
      end
      checks++;
      if (o_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_o_ready got=%b exp=0", o_ready);
      end
      mon = 1'b1;
   endtask

   task automatic test_sequence();
      hold_rst();
      release_rst();
      for (int k = 0; k < S; k++) begin
         wait_to(base + 2 + LF + H * (k + 1) - 1);
         checks++;
         if (o_rst[k] !== 1'b1) begin
            errors++;
            $display("FAIL seq_early bit=%0d got=%b exp=1", k, o_rst[k]);
         end
         checks++;
         if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL seq_ready_early bit=%0d got=%b exp=0", k, o_ready);
         end
         wait_to(base + 2 + LF + H * (k + 1));
         checks++;
         if (o_rst[k] !== 1'b0) begin
            errors++;
            $display("FAIL seq_release bit=%0d got=%b exp=0", k, o_rst[k]);
         end
      end
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL seq_ready got=%b exp=1", o_ready);
      end
   endtask

   task automatic test_async();
      hold_rst();
      release_rst();
      wait_to(base + 2 + 30);
      #1;
      checks++;
      if (o_rst !== {{(S-1){1'b1}}, 1'b0}) begin
         errors++;
         $display("FAIL async_pre got=%b exp=%b", o_rst, {{(S-1){1'b1}}, 1'b0});
      end
      rst = 1'b1;
      #1;
      checks++;
      if (o_rst !== {S{1'b1}}) begin
         errors++;
         $display("FAIL async_o_rst got=%b exp=%b", o_rst, {S{1'b1}});
      end
      checks++;
      if (o_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_o_ready got=%b exp=0", o_ready);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_glitch();
      release_rst();
      wait_to(base + 5);
      #1;
      locked = 1'b0;
      wait_to(base + 6);
      #1;
      locked = 1'b1;
      wait_to(base + 31);
      checks++;
      if (o_rst[0] !== 1'b1) begin
         errors++;
         $display("FAIL glitch_early got=%b exp=1", o_rst[0]);
      end
      wait_to(base + 32);
      checks++;
      if (o_rst[0] !== 1'b0) begin
         errors++;
         $display("FAIL glitch_release got=%b exp=0", o_rst[0]);
      end
      wait_to(base + 79);
      checks++;
      if (o_ready !== 1'b0) begin
         errors++;
         $display("FAIL glitch_ready_early got=%b exp=0", o_ready);
      end
      wait_to(base + 80);
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL glitch_ready got=%b exp=1", o_ready);
      end
   endtask

   task automatic test_sw_rst();
      int s;
      wait_to(cyc + 3);
      #1;
      sw_rst = 1'b1;
      s = cyc + 1;
      wait_to(s);
      checks++;
      if (o_rst !== {S{1'b1}} || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL swrst_assert got=%b/%b exp=%b/0", o_rst, o_ready, {S{1'b1}});
      end
      #1;
      sw_rst = 1'b0;
      wait_to(s + 23);
      checks++;
      if (o_rst[0] !== 1'b1) begin
         errors++;
         $display("FAIL swrst_early got=%b exp=1", o_rst[0]);
      end
      wait_to(s + 24);
      checks++;
      if (o_rst[0] !== 1'b0) begin
         errors++;
         $display("FAIL swrst_release got=%b exp=0", o_rst[0]);
      end
      wait_to(s + 40);
      checks++;
      if (o_rst[1] !== 1'b0) begin
         errors++;
         $display("FAIL swrst_release1 got=%b exp=0", o_rst[1]);
      end
      wait_to(s + 71);
      checks++;
      if (o_ready !== 1'b0) begin
         errors++;
         $display("FAIL swrst_ready_early got=%b exp=0", o_ready);
      end
      wait_to(s + 72);
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL swrst_ready got=%b exp=1", o_ready);
      end
   endtask

   task automatic test_drop();
      hold_rst();
      release_rst();
      wait_to(base + 55);
      #1;
      locked = 1'b0;
      wait_to(base + 57);
      checks++;
      if (o_rst !== {{(S-2){1'b1}}, 2'b00}) begin
         errors++;
         $display("FAIL drop_pre got=%b exp=%b", o_rst, {{(S-2){1'b1}}, 2'b00});
      end
      wait_to(base + 58);
      checks++;
      if (o_rst !== {S{1'b1}} || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL drop_fault got=%b/%b exp=%b/0", o_rst, o_ready, {S{1'b1}});
      end
      wait_to(base + 70);
      checks++;
      if (o_rst[2] !== 1'b1) begin
         errors++;
         $display("FAIL drop_bit2 got=%b exp=1", o_rst[2]);
      end
      #1;
      locked = 1'b1;
   endtask

   task automatic test_random();
      int ready_cycles = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #2;
         rst = ($urandom_range(0, 999) == 0);
         locked = ($urandom_range(0, 249) != 0);
         sw_rst = ($urandom_range(0, 399) == 0);
         if (o_ready) ready_cycles++;
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      locked = 1'b1;
      sw_rst = 1'b0;
      checks++;
      if (ready_cycles == 0) begin
         errors++;
         $display("FAIL random_ready_seen got=%0d exp>0", ready_cycles);
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_async();
      test_glitch();
      test_sw_rst();
      test_drop();
      test_random();
      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
